mux_pipe_stage: RTL and testbench
=================================

MUX_PIPE_STAGE -- requirements
Module: mux_pipe_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of every input and of the output.
REQ-002 SHALL have parameter NUM_IN, default 4, number of selectable inputs (legal range 2..16).
REQ-003 SHALL derive local constant SEL_W = clog2(NUM_IN); it is not overridable.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
REQ-007 sel  input  SEL_W  binary select, sampled with in_data.
REQ-008 in_valid  input  1  upstream offers in_data/sel this cycle.
REQ-009 in_ready  output  1  stage accepts this cycle.
REQ-010 flush  input  1  discard all buffered entries.
REQ-011 out_data  output  WIDTH  selected, registered data.
REQ-012 out_sel  output  SEL_W  select value that produced out_data.
REQ-013 out_valid  output  1  out_data/out_sel valid.
REQ-014 out_ready  input  1  downstream accepts this cycle.

Function
REQ-015 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-016 Selected value SHALL be input[sel] when sel < NUM_IN, else input 0.
REQ-017 Stage SHALL be a 2-entry skid buffer: main register (drives outputs) plus skid register.
REQ-018 States SHALL be EMPTY (0 entries), HALF (1), FULL (2).
REQ-019 EMPTY: transfer in -> HALF, main loaded; latency in->out_valid is exactly 1 cycle.
REQ-020 HALF: in only -> FULL (skid loaded); out only -> EMPTY; in and out same cycle -> HALF, main reloaded with new entry.
REQ-021 FULL: out -> HALF, main loaded from skid; in_ready is 0, so no transfer in.
REQ-022 in_ready SHALL be registered and equal (state != FULL); it never depends combinationally on out_ready.
REQ-023 out_valid SHALL equal (state != EMPTY); out_data/out_sel SHALL stay stable while out_valid && !out_ready.
REQ-024 Ordering SHALL be strict FIFO; no entry is dropped or duplicated except by flush/reset.
REQ-025 flush SHALL force EMPTY next cycle and discard any same-cycle transfer in; flush overrides all other events.
REQ-026 out_data/out_sel SHALL hold their last values when EMPTY (not cleared) except after reset.

Reset
REQ-027 reset SHALL force state EMPTY, out_valid 0, in_ready 1, out_data 0, out_sel 0, skid register 0.
REQ-028 reset mid-transfer SHALL discard all entries; reset has priority over flush and handshakes.

Configuration
REQ-029 Macro MUX_PIPE_SEL_ERR_EN, when defined, SHALL add output sel_err (1 bit): sticky, set the cycle after a transfer in with sel >= NUM_IN, cleared only by reset.
REQ-030 Without MUX_PIPE_SEL_ERR_EN, port sel_err SHALL not exist and out-of-range sel silently selects input 0.

Structure
REQ-031 Package mux_pkg SHALL hold the state enum (EMPTY/HALF/FULL) and default constants DEF_WIDTH=32, DEF_NUM_IN=4.
REQ-032 Combinational N-way selector SHALL be a sub-module mux_n (parameters WIDTH, NUM_IN; ports result, s, in_data), instantiated once.

Verification
REQ-033 WIDTH=32, NUM_IN=4, out_ready=1, inputs 0x11,0x22,0x33,0x44, sel=2 -> next cycle out_data=0x33, out_sel=2, out_valid=1.
REQ-034 out_ready=0, push A,B -> in_ready=0 after 2nd push; 3rd push blocked; release out_ready -> A then B, no loss.
REQ-035 Continuous in_valid/out_ready=1 for 100 random entries -> throughput 1/cycle, order preserved, state stays HALF.
REQ-036 FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; flushed/offered entries never appear.
REQ-037 NUM_IN=3, sel=3 with MUX_PIPE_SEL_ERR_EN -> out_data=input 0, sel_err=1 and stays 1 until reset.
REQ-038 reset asserted while FULL with out_ready=0 -> next cycle out_valid=0, out_data=0, in_ready=1.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and defaults for the registered N-way mux pipeline stage.
package mux_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NUM_IN = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/mux_pipe_stage_mux_n.sv
// Combinational N-way selector; out-of-range selects fall back to input 0.
module mux_n
  import mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  output logic [WIDTH-1:0]        result,
  input  logic [SEL_W-1:0]        s,
  input  logic [NUM_IN*WIDTH-1:0] in_data
);

  always_comb begin
    // NOTE: the default assignment ahead of the loop keeps every path driven, so no latch is inferred.
    result = in_data[0 +: WIDTH];
    for (int k = 1; k < NUM_IN; k++) begin
      if (s == SEL_W'(k)) result = in_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_pipe_stage.sv
// Registered N-way mux with a 2-entry skid buffer (valid/ready on both sides).
// Optional sticky out-of-range select flag: define MUX_PIPE_SEL_ERR_EN.
module mux_pipe_stage
  import mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef MUX_PIPE_SEL_ERR_EN
  ,
  output logic                    sel_err
`endif
);

  state_t             state;
  logic [WIDTH-1:0]   main_data;
  logic [SEL_W-1:0]   main_sel;
  logic [WIDTH-1:0]   skid_data;
  logic [SEL_W-1:0]   skid_sel;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [WIDTH-1:0]   sel_data;
  logic               in_fire;
  logic               out_fire;

  mux_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .result  (sel_data),
    .s       (sel),
    .in_data (in_data)
  );

  assign in_fire  = in_valid && in_ready_r;
  assign out_fire = out_valid_r && out_ready;

  // Handshake flags are registered alongside the state so in_ready never
  // sees out_ready combinationally.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state       <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      main_data   <= '0;
      main_sel    <= '0;
      // NOTE: the skid register is reset explicitly even though it is only read after being loaded.
      skid_data   <= '0;
      skid_sel    <= '0;
    end else if (flush) begin
      state       <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_data   <= sel_data;
            main_sel    <= sel;
            state       <= HALF;
            out_valid_r <= 1'b1;
          end
        end
        HALF: begin
          if (in_fire && out_fire) begin
            main_data <= sel_data;
            main_sel  <= sel;
          end else if (in_fire) begin
            skid_data  <= sel_data;
            skid_sel   <= sel;
            state      <= FULL;
            in_ready_r <= 1'b0;
          end else if (out_fire) begin
            state       <= EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_data  <= skid_data;
            main_sel   <= skid_sel;
            state      <= HALF;
            in_ready_r <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef MUX_PIPE_SEL_ERR_EN
  // Sticky: only reset clears it; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err <= 1'b0;
    end else if (in_fire && (32'(sel) >= 32'(NUM_IN))) begin
      sel_err <= 1'b1;
    end
  end
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_data;
  assign out_sel   = main_sel;

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Directed bench: a 4-input/32-bit stage and a 3-input/8-bit stage for out-of-range select.
module tb_mux_pipe_stage;

  logic         clk;
  logic         reset;
  logic         flush;

  logic [127:0] a_in_data;
  logic [1:0]   a_sel;
  logic         a_in_valid;
  logic         a_in_ready;
  logic [31:0]  a_out_data;
  logic [1:0]   a_out_sel;
  logic         a_out_valid;
  logic         a_out_ready;
`ifdef MUX_PIPE_SEL_ERR_EN
  logic         a_sel_err;
`endif

  logic [23:0]  b_in_data;
  logic [1:0]   b_sel;
  logic         b_in_valid;
  logic         b_in_ready;
  logic [7:0]   b_out_data;
  logic [1:0]   b_out_sel;
  logic         b_out_valid;
  logic         b_out_ready;
`ifdef MUX_PIPE_SEL_ERR_EN
  logic         b_sel_err;
`endif

  int checks = 0;
  int errors = 0;

  mux_pipe_stage #(.WIDTH(32), .NUM_IN(4)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_data   (a_in_data),
    .sel       (a_sel),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .flush     (flush),
    .out_data  (a_out_data),
    .out_sel   (a_out_sel),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready)
`ifdef MUX_PIPE_SEL_ERR_EN
    ,
    .sel_err   (a_sel_err)
`endif
  );

  mux_pipe_stage #(.WIDTH(8), .NUM_IN(3)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_data   (b_in_data),
    .sel       (b_sel),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .flush     (1'b0),
    .out_data  (b_out_data),
    .out_sel   (b_out_sel),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready)
`ifdef MUX_PIPE_SEL_ERR_EN
    ,
    .sel_err   (b_sel_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [1:0] s);
    a_in_valid = 1'b1;
    a_sel      = s;
    step();
    a_in_valid = 1'b0;
  endtask

  logic [31:0] w [4];
  logic [31:0] exp_word;

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    a_in_data   = {32'h44, 32'h33, 32'h22, 32'h11};
    a_sel       = '0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    b_in_data   = {8'h30, 8'h20, 8'h10};
    b_sel       = '0;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;

    // Reset state
    step();
    reset = 1'b0;
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_in_ready",  32'(a_in_ready),  32'd1);
    check("rst_out_data",  a_out_data,       32'h0);
    check("rst_out_sel",   32'(a_out_sel),   32'd0);

    // Basic select with one-cycle latency
    a_out_ready = 1'b1;
    push_a(2'd2);
    check("basic_valid", 32'(a_out_valid), 32'd1);
    check("basic_data",  a_out_data,       32'h33);
    check("basic_sel",   32'(a_out_sel),   32'd2);
    check("basic_ready", 32'(a_in_ready),  32'd1);
    step();
    check("drain_valid", 32'(a_out_valid), 32'd0);
    check("empty_hold",  a_out_data,       32'h33);

    // Backpressure: A, B fill the buffer, C is refused
    a_out_ready = 1'b0;
    push_a(2'd0);
    check("bp_a_ready", 32'(a_in_ready), 32'd1);
    check("bp_a_data",  a_out_data,      32'h11);
    push_a(2'd1);
    check("bp_full_ready", 32'(a_in_ready), 32'd0);
    check("bp_full_data",  a_out_data,      32'h11);
    push_a(2'd3);
    check("bp_block_ready", 32'(a_in_ready), 32'd0);
    check("bp_stable_data", a_out_data,      32'h11);
    check("bp_stable_sel",  32'(a_out_sel),  32'd0);
    a_out_ready = 1'b1;
    step();
    check("bp_b_valid", 32'(a_out_valid), 32'd1);
    check("bp_b_data",  a_out_data,       32'h22);
    check("bp_b_sel",   32'(a_out_sel),   32'd1);
    check("bp_b_ready", 32'(a_in_ready),  32'd1);
    step();
    check("bp_no_c", 32'(a_out_valid), 32'd0);

    // Streaming: one entry per cycle, in order
    for (int i = 0; i < 100; i++) begin
      for (int j = 0; j < 4; j++) w[j] = $urandom;
      a_in_data  = {w[3], w[2], w[1], w[0]};
      a_sel      = 2'($urandom_range(0, 3));
      exp_word   = w[a_sel];
      a_in_valid = 1'b1;
      step();
      check("stream_valid", 32'(a_out_valid), 32'd1);
      check("stream_data",  a_out_data,       exp_word);
      check("stream_ready", 32'(a_in_ready),  32'd1);
    end
    a_in_valid = 1'b0;
    step();
    check("stream_end_valid", 32'(a_out_valid), 32'd0);

    // Flush from FULL with a simultaneous offer
    a_in_data   = {32'h44, 32'h33, 32'h22, 32'h11};
    a_out_ready = 1'b0;
    push_a(2'd0);
    push_a(2'd1);
    check("fl_full_ready", 32'(a_in_ready), 32'd0);
    flush      = 1'b1;
    a_in_valid = 1'b1;
    a_sel      = 2'd3;
    step();
    flush      = 1'b0;
    a_in_valid = 1'b0;
    check("fl_valid", 32'(a_out_valid), 32'd0);
    check("fl_ready", 32'(a_in_ready),  32'd1);
    a_out_ready = 1'b1;
    step();
    check("fl_stays_empty", 32'(a_out_valid), 32'd0);
    push_a(2'd2);
    check("fl_next_data",  a_out_data,       32'h33);
    check("fl_next_valid", 32'(a_out_valid), 32'd1);
    step();
    check("fl_no_ghost", 32'(a_out_valid), 32'd0);

    // Three-input stage: out-of-range select falls back to input 0
`ifdef MUX_PIPE_SEL_ERR_EN
    check("b_err_init", 32'(b_sel_err), 32'd0);
`endif
    b_in_valid = 1'b1;
    b_sel      = 2'd3;
    step();
    check("b_oor_data",  32'(b_out_data),  32'h10);
    check("b_oor_valid", 32'(b_out_valid), 32'd1);
`ifdef MUX_PIPE_SEL_ERR_EN
    check("b_err_set", 32'(b_sel_err), 32'd1);
`endif
    b_sel = 2'd2;
    step();
    b_in_valid = 1'b0;
    check("b_top_data", 32'(b_out_data), 32'h30);
    step();
    step();
    check("b_idle_valid", 32'(b_out_valid), 32'd0);
`ifdef MUX_PIPE_SEL_ERR_EN
    check("b_err_sticky", 32'(b_sel_err), 32'd1);
`endif

    // Reset while FULL and stalled
    a_out_ready = 1'b0;
    push_a(2'd1);
    push_a(2'd2);
    check("rf_full_ready", 32'(a_in_ready), 32'd0);
    reset      = 1'b1;
    a_in_valid = 1'b1;
    a_sel      = 2'd3;
    step();
    reset      = 1'b0;
    a_in_valid = 1'b0;
    check("rf_valid", 32'(a_out_valid), 32'd0);
    check("rf_data",  a_out_data,       32'h0);
    check("rf_sel",   32'(a_out_sel),   32'd0);
    check("rf_ready", 32'(a_in_ready),  32'd1);
    check("rf_b_data", 32'(b_out_data), 32'h0);
`ifdef MUX_PIPE_SEL_ERR_EN
    check("rf_b_err_clr", 32'(b_sel_err), 32'd0);
`endif

    // Post-reset ordering through the skid register
    push_a(2'd3);
    push_a(2'd0);
    check("pr_first_data", a_out_data,      32'h44);
    check("pr_full_ready", 32'(a_in_ready), 32'd0);
    a_out_ready = 1'b1;
    step();
    check("pr_second_data", a_out_data,       32'h11);
    check("pr_second_sel",  32'(a_out_sel),   32'd0);
    step();
    check("pr_drained", 32'(a_out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
